// File: rtl/sram_bus_responder.sv
// Bus slave that runs single-word MMU requests against a 32-bit async SRAM with fixed wait states.
// Optional BUS_RSP_DUMMY_ACK_EN: unmapped requests get a zero-data ack instead of being ignored.
module sram_bus_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bus_ce_i,
  input  logic               bus_we_i,
  input  logic [31:0]        bus_addr_i,
  input  logic [31:0]        bus_data_i,
  input  logic [15:0]        bus_select_i,
  output logic [31:0]        bus_data_o,
  output logic               bus_ack_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_data_o,
  input  logic [31:0]        sram_data_i,
  output logic               sram_data_oe_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ACK, RECOVER} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, cnt_d;
  logic          we_q, sram_q;
  logic [31:0]   rd_q, rd_d, bus_data_d;
  logic          valid_req, sram_req, accept;
  logic          op_we, op_sram, active, capture;

  // Byte-lane and aliased upper address bits carry no meaning for a word-wide SRAM.
  logic unused_addr;
  assign unused_addr = ^{bus_addr_i[31:SRAM_AW+2], bus_addr_i[1:0]};

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    next_state = state;
    cnt_d      = cnt;
    valid_req  = bus_ce_i && (bus_select_i != '0);
    sram_req   = valid_req && bus_select_i[0];

    unique case (state)
      IDLE: begin
        if (sram_req) begin
          next_state = SETUP;
        end
`ifdef BUS_RSP_DUMMY_ACK_EN
        else if (valid_req) begin
          next_state = ACK;
        end
`endif
      end
      SETUP: begin
        next_state = ACCESS;
        cnt_d      = '0;
      end
      ACCESS: begin
        if (cnt == CW'(WAIT_CYCLES - 1)) next_state = ACK;
        else                             cnt_d      = cnt + 1'b1;
      end
      ACK:     next_state = RECOVER;
      RECOVER: next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // In IDLE the request is being latched this edge, so decode it straight from the bus.
    accept  = (state == IDLE) && (next_state != IDLE);
    op_we   = (state == IDLE) ? bus_we_i : we_q;
    op_sram = (state == IDLE) ? sram_req : sram_q;
    active  = op_sram && (next_state inside {SETUP, ACCESS, ACK});

    capture    = (state == ACCESS) && (next_state == ACK) && !we_q;
    rd_d       = capture ? sram_data_i : rd_q;
    bus_data_d = (next_state == ACK) ? (capture ? rd_d : '0) : rd_d;
  end

  // Outputs are registered from the next-state decode so each pin reflects the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      we_q           <= 1'b0;
      sram_q         <= 1'b0;
      rd_q           <= '0;
      bus_ack_o      <= 1'b0;
      bus_data_o     <= '0;
      sram_addr_o    <= '0;
      sram_data_o    <= '0;
      sram_data_oe_o <= 1'b0;
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= next_state;
      cnt   <= cnt_d;
      rd_q  <= rd_d;
      if (accept) begin
        we_q   <= bus_we_i;
        sram_q <= sram_req;
        if (sram_req) begin
          sram_addr_o <= bus_addr_i[SRAM_AW+1:2];
          sram_data_o <= bus_data_i;
        end
      end
      bus_ack_o      <= (next_state == ACK);
      bus_data_o     <= bus_data_d;
      sram_ce_n_o    <= !active;
      sram_oe_n_o    <= !(active && !op_we);
      sram_we_n_o    <= !(op_sram && op_we && (next_state == ACCESS));
      sram_data_oe_o <= active && op_we;
    end
  end

endmodule
